// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - three-master fixed-priority bus arbiter with burst fairness and ack timeout
module bus_arbiter #(
  parameter int BURST_LIMIT = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_vga_cs,
  input  logic        i_uart_cs,
  input  logic        i_cpu_cs,
  input  logic        i_vga_we,
  input  logic        i_uart_we,
  input  logic        i_cpu_we,
  input  logic [15:0] i_vga_addr,
  input  logic [15:0] i_uart_addr,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_vga_dat,
  input  logic [7:0]  i_uart_dat,
  input  logic [7:0]  i_cpu_dat,
  output logic        o_vga_ack,
  output logic        o_uart_ack,
  output logic        o_cpu_ack,
  output logic [15:0] o_addr,
  output logic [7:0]  o_dat,
  output logic        o_we,
  output logic        o_cs,
  input  logic        i_ack,
  output logic [2:0]  o_grant,
  output logic        o_timeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} state_t;

  localparam logic [31:0] BURST_LIM  = 32'(BURST_LIMIT);
  localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  mask_q, mask_d;
  logic [7:0]  burst_q, burst_d;
  logic [7:0]  wait_q, wait_d;
  logic        timeout_q, timeout_d;
  logic [2:0]  cs_vec, we_vec, req_unmasked, req_eff;
  logic [8:0]  burst_inc;
  logic        ack_any, others_req, burst_hit;

  assign cs_vec     = {i_vga_cs, i_uart_cs, i_cpu_cs};
  assign we_vec     = {i_vga_we, i_uart_we, i_cpu_we};
  assign o_cs       = |(grant_q & cs_vec);
  assign o_we       = |(grant_q & we_vec);
  // timeout_q is high exactly in the cycle where the waiting count reaches TIMEOUT
  assign ack_any    = o_cs & (i_ack | timeout_q);
  assign o_vga_ack  = grant_q[2] & ack_any;
  assign o_uart_ack = grant_q[1] & ack_any;
  assign o_cpu_ack  = grant_q[0] & ack_any;
  assign o_grant    = grant_q;
  assign o_timeout  = timeout_q;

  assign others_req = |(cs_vec & ~grant_q);
  assign burst_inc  = {1'b0, burst_q} + 9'd1;
  assign burst_hit  = (BURST_LIMIT != 0) && ({23'd0, burst_inc} == BURST_LIM);

  always_comb begin
    o_addr = '0;
    o_dat  = '0;
    case (grant_q)
      3'b100: begin o_addr = i_vga_addr;  o_dat = i_vga_dat;  end
      3'b010: begin o_addr = i_uart_addr; o_dat = i_uart_dat; end
      3'b001: begin o_addr = i_cpu_addr;  o_dat = i_cpu_dat;  end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    mask_d       = mask_q;
    burst_d      = burst_q;
    wait_d       = wait_q;
    req_unmasked = cs_vec & ~mask_q;
    // a masked master still wins when nobody else is asking
    req_eff      = (|req_unmasked) ? req_unmasked : cs_vec;
    case (state_q)
      IDLE: begin
        if (|cs_vec) begin
          state_d = GRANT;
          mask_d  = 3'b000;
          if (req_eff[2])      grant_d = 3'b100;
          else if (req_eff[1]) grant_d = 3'b010;
          else                 grant_d = 3'b001;
        end
      end
      GRANT: begin
        if (!o_cs) begin
          state_d = TURN;
          grant_d = 3'b000;
        end else if (ack_any) begin
          burst_d = (burst_q == 8'hff) ? 8'hff : burst_q + 8'd1;
          wait_d  = 8'd0;
          if (burst_hit && others_req) begin
            state_d = TURN;
            grant_d = 3'b000;
            mask_d  = grant_q;
          end
        end else begin
          wait_d = (wait_q == 8'hff) ? 8'hff : wait_q + 8'd1;
        end
      end
      TURN: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    endcase
    if (state_d != GRANT) begin
      burst_d = 8'd0;
      wait_d  = 8'd0;
    end
    timeout_d = (TIMEOUT != 0) && (state_d == GRANT) && ({24'd0, wait_d} == TIMEOUT_M1);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      grant_q   <= 3'b000;
      mask_q    <= 3'b000;
      burst_q   <= 8'd0;
      wait_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      mask_q    <= mask_d;
      burst_q   <= burst_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed bench for bus_arbiter with a cycle-level ownership model
module tb_bus_arbiter;

  localparam int BL = 8;
  localparam int TO = 4;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_vga_cs, i_uart_cs, i_cpu_cs;
  logic        i_vga_we, i_uart_we, i_cpu_we;
  logic [15:0] i_vga_addr, i_uart_addr, i_cpu_addr;
  logic [7:0]  i_vga_dat, i_uart_dat, i_cpu_dat;
  logic        o_vga_ack, o_uart_ack, o_cpu_ack;
  logic [15:0] o_addr;
  logic [7:0]  o_dat;
  logic        o_we, o_cs, i_ack, o_timeout;
  logic [2:0]  o_grant;

  always #5 i_clk = ~i_clk;

  bus_arbiter #(.BURST_LIMIT(BL), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_vga_cs(i_vga_cs), .i_uart_cs(i_uart_cs), .i_cpu_cs(i_cpu_cs),
    .i_vga_we(i_vga_we), .i_uart_we(i_uart_we), .i_cpu_we(i_cpu_we),
    .i_vga_addr(i_vga_addr), .i_uart_addr(i_uart_addr), .i_cpu_addr(i_cpu_addr),
    .i_vga_dat(i_vga_dat), .i_uart_dat(i_uart_dat), .i_cpu_dat(i_cpu_dat),
    .o_vga_ack(o_vga_ack), .o_uart_ack(o_uart_ack), .o_cpu_ack(o_cpu_ack),
    .o_addr(o_addr), .o_dat(o_dat), .o_we(o_we), .o_cs(o_cs), .i_ack(i_ack),
    .o_grant(o_grant), .o_timeout(o_timeout)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cpu_acks = 0;
  int base;
  // owner: -1 none, 0 cpu, 1 uart, 2 vga; gap counts dead cycles before arbitration resumes
  int m_owner, m_gap, m_excl, m_acks, m_waits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_excl = -1; m_acks = 0; m_waits = 0;
  endtask

  task automatic model_release();
    m_owner = -1; m_gap = 1; m_acks = 0; m_waits = 0;
  endtask

  task automatic model_advance();
    logic [2:0] cs, cand, others;
    bit forced, acked;
    cs = {i_vga_cs, i_uart_cs, i_cpu_cs};
    if (!i_reset_n) begin
      model_reset();
    end else if (m_owner < 0) begin
      if (m_gap > 0) m_gap = m_gap - 1;
      else if (cs != 3'b000) begin
        cand = cs;
        if (m_excl >= 0 && (cs & ~(3'b001 << m_excl)) != 3'b000) cand = cs & ~(3'b001 << m_excl);
        m_owner = cand[2] ? 2 : (cand[1] ? 1 : 0);
        m_excl = -1; m_acks = 0; m_waits = 0;
      end
    end else begin
      forced = (TO > 0) && (m_waits == TO - 1);
      acked  = cs[m_owner] && (i_ack || forced);
      others = cs;
      others[m_owner] = 1'b0;
      if (!cs[m_owner]) model_release();
      else if (acked) begin
        m_acks  = (m_acks < 255) ? m_acks + 1 : 255;
        m_waits = 0;
        if (BL > 0 && m_acks == BL && others != 3'b000) begin
          m_excl = m_owner;
          model_release();
        end
      end else m_waits = (m_waits < 255) ? m_waits + 1 : 255;
    end
  endtask

  task automatic compare_cycle();
    logic [2:0]  cs, we, eg, eack;
    logic [15:0] addrs [3];
    logic [7:0]  dats [3];
    logic [15:0] ea;
    logic [7:0]  ed;
    logic        ecs, ewe, etmo;
    cs = {i_vga_cs, i_uart_cs, i_cpu_cs};
    we = {i_vga_we, i_uart_we, i_cpu_we};
    addrs[0] = i_cpu_addr; addrs[1] = i_uart_addr; addrs[2] = i_vga_addr;
    dats[0]  = i_cpu_dat;  dats[1]  = i_uart_dat;  dats[2]  = i_vga_dat;
    eg = 3'b000; ecs = 1'b0; ewe = 1'b0; ea = '0; ed = '0; etmo = 1'b0; eack = 3'b000;
    if (m_owner >= 0) begin
      eg   = 3'b001 << m_owner;
      ecs  = cs[m_owner];
      ewe  = we[m_owner];
      ea   = addrs[m_owner];
      ed   = dats[m_owner];
      etmo = (TO > 0) && (m_waits == TO - 1);
      eack = (ecs && (i_ack || etmo)) ? eg : 3'b000;
    end
    check("grant",   32'(o_grant), 32'(eg));
    check("cs",      32'(o_cs), 32'(ecs));
    check("we",      32'(o_we), 32'(ewe));
    check("addr",    32'(o_addr), 32'(ea));
    check("dat",     32'(o_dat), 32'(ed));
    check("acks",    32'({o_vga_ack, o_uart_ack, o_cpu_ack}), 32'(eack));
    check("timeout", 32'(o_timeout), 32'(etmo));
    cpu_acks = cpu_acks + int'(o_cpu_ack);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      compare_cycle();
      @(posedge i_clk);
      model_advance();
      #2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    i_reset_n = 1'b1; i_ack = 1'b0;
    {i_vga_cs, i_uart_cs, i_cpu_cs} = 3'b000;
    {i_vga_we, i_uart_we, i_cpu_we} = 3'b000;
    i_vga_addr = '0; i_uart_addr = '0; i_cpu_addr = '0;
    i_vga_dat = '0; i_uart_dat = '0; i_cpu_dat = '0;
    model_reset();
    #1 i_reset_n = 1'b0;
    model_reset();
    step(2);
    check("reset_grant", 32'(o_grant), 32'h0);
    check("reset_cs", 32'(o_cs), 32'h0);
    check("reset_timeout", 32'(o_timeout), 32'h0);
    i_reset_n = 1'b1;
    step(1);
    check("idle_grant", 32'(o_grant), 32'h0);

    // single CPU read, slave acks in the third granted cycle
    base = cpu_acks;
    i_cpu_cs = 1'b1; i_cpu_addr = 16'h1234;
    step(1);
    check("cpu_grant", 32'(o_grant), 32'h1);
    check("cpu_addr", 32'(o_addr), 32'h1234);
    step(2);
    i_ack = 1'b1;
    step(1);
    i_ack = 1'b0; i_cpu_cs = 1'b0;
    step(1);
    check("cpu_turn_grant", 32'(o_grant), 32'h0);
    check("cpu_turn_cs", 32'(o_cs), 32'h0);
    check("cpu_one_ack", 32'(cpu_acks - base), 32'd1);
    step(1);

    // three simultaneous requests served in priority order
    i_vga_cs = 1'b1;  i_vga_addr = 16'hA000;  i_vga_dat = 8'h11;  i_vga_we = 1'b1;
    i_uart_cs = 1'b1; i_uart_addr = 16'hB000; i_uart_dat = 8'h22; i_uart_we = 1'b0;
    i_cpu_cs = 1'b1;  i_cpu_addr = 16'hC000;  i_cpu_dat = 8'h33;  i_cpu_we = 1'b1;
    step(1);
    check("pri_vga", 32'(o_grant), 32'h4);
    check("pri_vga_addr", 32'(o_addr), 32'hA000);
    i_ack = 1'b1; step(1); i_ack = 1'b0; i_vga_cs = 1'b0; i_vga_we = 1'b0;
    step(3);
    check("pri_uart", 32'(o_grant), 32'h2);
    check("pri_uart_addr", 32'(o_addr), 32'hB000);
    i_ack = 1'b1; step(1); i_ack = 1'b0; i_uart_cs = 1'b0;
    step(3);
    check("pri_cpu", 32'(o_grant), 32'h1);
    check("pri_cpu_dat", 32'(o_dat), 32'h33);
    i_ack = 1'b1; step(1); i_ack = 1'b0; i_cpu_cs = 1'b0; i_cpu_we = 1'b0;
    step(3);

    // CPU bursting with ack every cycle, preempted by UART after its 8th ack
    base = cpu_acks;
    i_cpu_cs = 1'b1; i_cpu_addr = 16'h0400; i_ack = 1'b1;
    step(1);
    check("burst_cpu_grant", 32'(o_grant), 32'h1);
    step(1);
    i_uart_cs = 1'b1; i_uart_addr = 16'h0500;
    step(6);
    check("burst_cpu_8th", 32'(o_grant), 32'h1);
    step(1);
    check("burst_turn", 32'(o_grant), 32'h0);
    step(2);
    check("burst_uart_grant", 32'(o_grant), 32'h2);
    check("burst_cpu_acks", 32'(cpu_acks - base), 32'd8);
    step(1);
    i_uart_cs = 1'b0;
    step(3);
    check("burst_cpu_regrant", 32'(o_grant), 32'h1);
    i_cpu_cs = 1'b0; i_ack = 1'b0;
    step(3);

    // VGA preempted by the lower-priority CPU; mask keeps VGA out once
    i_vga_cs = 1'b1; i_vga_addr = 16'h8000; i_ack = 1'b1;
    step(1);
    check("mask_vga_grant", 32'(o_grant), 32'h4);
    i_cpu_cs = 1'b1;
    step(8);
    check("mask_turn", 32'(o_grant), 32'h0);
    step(2);
    check("mask_cpu_wins", 32'(o_grant), 32'h1);
    step(1);
    i_cpu_cs = 1'b0;
    step(3);
    check("mask_vga_back", 32'(o_grant), 32'h4);
    i_vga_cs = 1'b0; i_ack = 1'b0;
    step(3);

    // timeout: slave never answers
    i_cpu_cs = 1'b1; i_cpu_addr = 16'h0F00;
    step(1);
    check("to_grant", 32'(o_grant), 32'h1);
    step(2);
    check("to_not_yet", 32'(o_timeout), 32'h0);
    step(1);
    check("to_pulse", 32'(o_timeout), 32'h1);
    check("to_forced_ack", 32'(o_cpu_ack), 32'h1);
    step(1);
    check("to_clear", 32'(o_timeout), 32'h0);
    i_cpu_cs = 1'b0;
    step(3);

    // asynchronous reset in the middle of a UART write
    i_uart_cs = 1'b1; i_uart_we = 1'b1; i_uart_addr = 16'h2222; i_uart_dat = 8'hA5;
    step(1);
    check("rst_pre_grant", 32'(o_grant), 32'h2);
    check("rst_pre_we", 32'(o_we), 32'h1);
    #1 i_reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_cs", 32'(o_cs), 32'h0);
    check("rst_async_we", 32'(o_we), 32'h0);
    check("rst_async_grant", 32'(o_grant), 32'h0);
    step(1);
    i_reset_n = 1'b1;
    check("rst_release_grant", 32'(o_grant), 32'h0);
    step(1);
    check("rst_fresh_grant", 32'(o_grant), 32'h2);
    i_ack = 1'b1; step(1); i_ack = 1'b0; i_uart_cs = 1'b0; i_uart_we = 1'b0;
    step(3);

    // stray slave ack with no owner, then ack followed by an immediate cs drop
    base = cpu_acks;
    i_ack = 1'b1;
    step(2);
    check("stray_grant", 32'(o_grant), 32'h0);
    check("stray_no_ack", 32'(cpu_acks - base), 32'd0);
    i_ack = 1'b0;
    i_cpu_cs = 1'b1; i_cpu_we = 1'b1; i_cpu_dat = 8'h5A; i_cpu_addr = 16'h3000;
    step(2);
    i_ack = 1'b1;
    step(1);
    i_ack = 1'b0; i_cpu_cs = 1'b0; i_cpu_we = 1'b0;
    step(1);
    check("drop_turn", 32'(o_grant), 32'h0);
    check("drop_one_ack", 32'(cpu_acks - base), 32'd1);
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Three-master arbiter for the shared 16-bit-address / 8-bit-data external memory bus. Masters are the VGA fetcher, the UART debug master and the tv80 CPU.
- Replaces the ad-hoc one-cycle "active" flags in the top level with registered grant, burst fairness and an ack timeout.
- Sits between the masters and the top-level o_addr/o_dat/o_we/o_cs/i_ack pins.
- Read data (i_dat) is broadcast to all masters outside this block.

Parameters:
- BURST_LIMIT, 8: acks a master may receive in one tenure before yielding to a waiting requester; 0 disables preemption.
- TIMEOUT, 255: cycles o_cs may stay high without i_ack before a forced ack; 0 disables; max 255.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_vga_cs, i_uart_cs, i_cpu_cs  in  1 each  master request, held until acked
- i_vga_we, i_uart_we, i_cpu_we  in  1 each  master write enable
- i_vga_addr, i_uart_addr, i_cpu_addr  in  16 each  master address
- i_vga_dat, i_uart_dat, i_cpu_dat  in  8 each  master write data
- o_vga_ack, o_uart_ack, o_cpu_ack  out  1 each  per-master ack
- o_addr  out  16  bus address
- o_dat  out  8  bus write data
- o_we  out  1  bus write enable
- o_cs  out  1  bus chip select
- i_ack  in  1  slave ack
- o_grant  out  3  one-hot grant, [2]=vga [1]=uart [0]=cpu
- o_timeout  out  1  one-cycle pulse on forced ack

Behaviour:
- Reset (async, i_reset_n low):
  - state=IDLE, o_grant=000, burst_cnt=0, wait_cnt=0, mask=000, o_timeout=0.
  - o_cs/o_we/o_addr/o_dat read 0; all acks 0.
  - Effect is immediate, including mid-transaction.
- Fixed priority: vga > uart > cpu, applied to requests not masked.
- IDLE:
  - At each edge, if any unmasked cs is high, register one-hot grant for the winner → GRANT.
  - Latency: cs high before edge N → o_grant and o_cs valid after edge N.
  - Clear mask on that edge.
- GRANT:
  - o_addr/o_dat/o_we combinationally follow the granted master.
  - o_cs = granted master's cs.
  - Other masters see ack 0.
  - o_<m>_ack = granted & o_cs & (i_ack | forced).
  - burst_cnt increments on each ack, saturating at 255.
  - Release to TURN at an edge when either:
    - (a) the granted cs is sampled low; or
    - (b) an ack occurs, burst_cnt+1 == BURST_LIMIT (BURST_LIMIT≠0), and any other cs is high.
  - On (b), set mask to the released master's bit.
  - Ack and cs-drop in the same cycle: ack is delivered and counted, release via (a), no mask.
- TURN: one dead cycle. o_grant=000, o_cs=0, burst_cnt=0, wait_cnt=0 → IDLE.
- Mask:
  - Excludes the preempted master from the next arbitration only.
  - If the masked master is the sole requester, it is still granted (mask ignored when no other request).
- Timeout:
  - In GRANT, wait_cnt increments each cycle with o_cs=1 and i_ack=0; it clears on ack.
  - When wait_cnt reaches TIMEOUT, assert forced ack to the granted master and o_timeout for exactly that cycle, then clear wait_cnt.
  - Write data is discarded; read data is undefined.
- i_ack while o_grant=000 or o_cs=0 is ignored.
- Granted master drops cs without an ack: no ack is generated, normal release.
- Outputs o_grant and o_timeout are registered. Bus mux and acks are combinational from registered grant.

Test Plan:
- Single CPU read: i_cpu_cs=1, addr 0x1234, i_ack at cycle 3 → grant=001 after first edge, o_addr=0x1234, o_cpu_ack pulses once, then TURN cycle with o_cs=0.
- Simultaneous vga+uart+cpu cs at the same edge → grant=100 first, then after vga drops cs and TURN, grant=010, then 001; no ack leaks to ungranted masters.
- Preemption with BURST_LIMIT=8: CPU holds cs with ack every cycle, UART requests at cycle 2 → CPU released right after its 8th ack, TURN, UART granted. With uart as the only other requester and CPU masked, CPU is regranted after the UART releases.
- Timeout with TIMEOUT=4: CPU cs high, i_ack never → o_cpu_ack and o_timeout high together at the 4th waiting cycle, then CPU may release.
- Async reset mid-write: assert i_reset_n=0 while grant=010 and o_we=1 → o_cs, o_we, o_grant go 0 without a clock edge; after release, a fresh request takes one cycle to grant.
- Ack coincident with cs drop, plus stray i_ack in IDLE → exactly one ack to the master, no mask set, stray ack produces no master ack.
